add_sequencer: RTL and testbench
================================

ADD_SEQUENCER -- requirements
Module: add_sequencer

Interface
REQ-001 Parameter N, default 8: word width of the shared adder datapath, in bits.
REQ-002 Parameter K, default 4: number of words per operand; K SHALL be at least 1.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port start, input, 1 bit: operation request, sampled on a clk rising edge.
REQ-006 Port A, input, N*K bits: operand A; word i is A[i*N +: N], and word 0 is least significant.
REQ-007 Port B, input, N*K bits: operand B, with the same word layout as A.
REQ-008 Port Cin, input, 1 bit: carry-in for word 0.
REQ-009 Port busy, output, 1 bit: high while an operation is in progress (RUN state).
REQ-010 Port done, output, 1 bit: high for exactly one cycle when S and Cout become valid.
REQ-011 Port S, output, N*K bits: multi-word sum.
REQ-012 Port Cout, output, 1 bit: carry-out of the most significant word.

Function
REQ-013 The block SHALL compute {Cout,S} = A + B + Cin, modulo 2^(N*K+1), using one N-bit adder instance over K cycles.
REQ-014 FSM states SHALL be IDLE, RUN and DONE, with the following transitions:
- IDLE -> RUN on start=1.
- RUN -> DONE after word K-1 is written.
- DONE -> IDLE unconditionally.
REQ-015 On accepting start in IDLE, the block SHALL latch A, B and Cin into internal registers, clear the word index to 0 and set the carry register to Cin; later changes on A, B or Cin SHALL NOT affect the result.
REQ-016 In RUN, each cycle SHALL do the following:
- Drive the adder with latched word[idx] of A and B, plus the carry register.
- Write the adder sum to S[idx*N +: N] on the next edge.
- Load the adder carry-out into the carry register.
- Increment idx.
REQ-017 Timing, with start sampled at edge 0:
- Word i SHALL be written at edge i+1.
- State SHALL be DONE after edge K, with done=1 for that one cycle.
- State SHALL return to IDLE at edge K+1.
REQ-018 Cout SHALL be loaded with the final carry at edge K.
REQ-019 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE; busy and done SHALL never both be high.
REQ-020 start SHALL be ignored in RUN and DONE; there is no queueing, so a requester must re-assert start once IDLE.
REQ-021 S and Cout SHALL hold their last values in IDLE until the next accepted start.
REQ-022 For K=1, RUN SHALL last exactly one cycle; the timing of REQ-017 applies with K=1.
REQ-023 idx SHALL be ceil(log2(K)) bits wide, minimum 1 bit, and SHALL NOT wrap during an operation.

Reset
REQ-024 While rst=1, the following SHALL be forced immediately, without waiting for a clock edge:
- State = IDLE.
- busy = 0 and done = 0.
- S = 0 and Cout = 0.
- idx = 0 and carry register = 0.
- Latched operands = 0.
REQ-025 Reset asserted mid-RUN SHALL abort the operation with no partial result retained; the first start after rst deasserts SHALL be serviced normally.

Structure
REQ-026 A shared package SHALL hold the state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the default N and K.
REQ-027 The datapath SHALL be exactly one instance of the existing parameterized adder, nAdder #(N).
REQ-028 add_sequencer SHALL contain only control logic, the operand and result registers, and the carry register.

Verification (N=8, K=4 unless stated)
REQ-029 A=32'h000000FA, B=32'h00000009, Cin=0 -> S=32'h00000103, Cout=0; done high only in the cycle after edge 4.
REQ-030 A=32'hFFFFFFFF, B=0, Cin=1 -> S=0, Cout=1; the carry ripples through all 4 words, and busy is high for 4 cycles.
REQ-031 start held high for 10 cycles with A=1, B=1, Cin=0 -> exactly two operations are accepted, at edge 0 and edge 6, each producing S=2, Cout=0; A/B changes during RUN do not alter S.
REQ-032 rst pulsed at edge 2 of an operation -> S=0, busy=0, done=0 immediately; then A=5, B=7, Cin=1 -> S=13 with normal latency.
REQ-033 K=1, N=8: A=250, B=9, Cin=1 -> S=4, Cout=1; done high in the cycle after edge 1.
REQ-034 Random self-check, 1000 operations against {Cout,S}=A+B+Cin -> zero mismatches; busy and done are never both high.

Source files
------------

// File: rtl/add_sequencer_pkg.sv
// Shared definitions for the multi-word add sequencer: state encoding and
// default datapath geometry.
package add_sequencer_pkg;

    localparam int N_DEF = 8;
    localparam int K_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/add_sequencer_if.sv
// Request/result bundle between a requester (master) and the add sequencer (slave).
interface add_sequencer_if
    import add_sequencer_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int K = K_DEF
);

    logic             start;
    logic [N*K-1:0]   A;
    logic [N*K-1:0]   B;
    logic             Cin;
    logic             busy;
    logic             done;
    logic [N*K-1:0]   S;
    logic             Cout;

    modport master (output start, A, B, Cin, input busy, done, S, Cout);
    modport slave  (input start, A, B, Cin, output busy, done, S, Cout);

endinterface

// File: rtl/nAdder.sv
// Plain N-bit ripple adder with carry in/out; the single shared datapath element.
module nAdder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/add_sequencer.sv
// Multi-word adder: computes {Cout,S} = A + B + Cin one N-bit word per cycle
// through a single shared nAdder, least significant word first.
module add_sequencer
    import add_sequencer_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int K = K_DEF
) (
    input  logic            clk,
    input  logic            rst,
    add_sequencer_if.slave  bus
);

    localparam int            IW   = (K > 1) ? $clog2(K) : 1;
    localparam logic [IW-1:0] LAST = IW'(K - 1);

    state_e                state_q;
    logic                  busy_q, done_q;
    logic [IW-1:0]         idx_q;
    logic                  cy_q;
    logic [K-1:0][N-1:0]   a_q, b_q, s_q;
    logic                  cout_q;

    logic [N-1:0]          wa_d, wb_d, sum_d;
    logic                  co_d;

    // Word select by comparison keeps the mux legal for any K, including 1.
    always_comb begin
        wa_d = '0;
        wb_d = '0;
        for (int k = 0; k < K; k++) begin
            if (idx_q == IW'(k)) begin
                wa_d = a_q[k];
                wb_d = b_q[k];
            end
        end
    end

    nAdder #(.N(N)) u_add (
        .a    (wa_d),
        .b    (wb_d),
        .cin  (cy_q),
        .sum  (sum_d),
        .cout (co_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
            cy_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.A;
                        b_q     <= bus.B;
                        cy_q    <= bus.Cin;
                        idx_q   <= '0;
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    for (int k = 0; k < K; k++) begin
                        if (idx_q == IW'(k)) s_q[k] <= sum_d;
                    end
                    cy_q <= co_d;
                    // idx parks on the last word rather than wrapping.
                    if (idx_q == LAST) begin
                        cout_q  <= co_d;
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.S    = s_q;
    assign bus.Cout = cout_q;

endmodule

// File: tb/tb_add_sequencer.sv
// Directed and random checks of add_sequencer at K=4 and K=1 (N=8).
module tb_add_sequencer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    add_sequencer_if #(.N(8), .K(4)) bus4 ();
    add_sequencer_if #(.N(8), .K(1)) bus1 ();

    add_sequencer #(.N(8), .K(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    add_sequencer #(.N(8), .K(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [32:0] exp;   // {Cout, S}
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Launch one K=4 operation from IDLE; scribble the inputs while running.
    task automatic op4(input logic [31:0] a, input logic [31:0] b, input logic cin,
                       input logic [32:0] exp, input string nm);
        bus4.A = a; bus4.B = b; bus4.Cin = cin; bus4.start = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            if (c == 0) bus4.start = 1'b0;
            if (c < 4) begin
                bus4.A   = $urandom;
                bus4.B   = $urandom;
                bus4.Cin = 1'($urandom);
            end
            chkb({nm, "/busy"}, bus4.busy, c < 4);
            chkb({nm, "/done"}, bus4.done, c == 4);
            if (c >= 4) chk({nm, "/sum"}, {bus4.Cout, bus4.S}, exp);
        end
    endtask

    vec_t tv[6];
    int   nacc, first_acc, second_acc;
    logic prev_busy;
    logic [31:0] ra, rb;
    logic        rc;

    initial begin
        tv[0] = '{32'h000000FA, 32'h00000009, 1'b0, 33'h0_00000103};
        tv[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 33'h1_00000000};
        tv[2] = '{32'h00000000, 32'h00000000, 1'b0, 33'h0_00000000};
        tv[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 33'h1_FFFFFFFF};
        tv[4] = '{32'h12345678, 32'h87654321, 1'b0, 33'h0_99999999};
        tv[5] = '{32'h80000000, 32'h80000000, 1'b0, 33'h1_00000000};

        rst = 1'b1;
        bus4.start = 1'b0; bus4.A = '0; bus4.B = '0; bus4.Cin = 1'b0;
        bus1.start = 1'b0; bus1.A = '0; bus1.B = '0; bus1.Cin = 1'b0;
        #3;
        chkb("reset/busy", bus4.busy, 1'b0);
        chkb("reset/done", bus4.done, 1'b0);
        chk("reset/sum", {bus4.Cout, bus4.S}, 33'h0);
        chk("reset/sum_k1", {24'h0, bus1.Cout, bus1.S}, 33'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++)
            op4(tv[i].a, tv[i].b, tv[i].cin, tv[i].exp, $sformatf("vec%0d", i));

        // start held high for 10 edges: accepts at edge 0 and edge 6 only
        bus4.A = 32'd1; bus4.B = 32'd1; bus4.Cin = 1'b0; bus4.start = 1'b1;
        nacc = 0; first_acc = -1; second_acc = -1; prev_busy = 1'b0;
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            if (bus4.busy && !prev_busy) begin
                if (nacc == 0) first_acc = c;
                else if (nacc == 1) second_acc = c;
                nacc++;
            end
            prev_busy = bus4.busy;
            if (c == 5) begin
                bus4.A = 32'd1; bus4.B = 32'd1;
            end else begin
                bus4.A = $urandom; bus4.B = $urandom;
            end
        end
        bus4.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("hold/accepts", 33'(nacc), 33'd2);
        chk("hold/first", 33'(first_acc), 33'd0);
        chk("hold/second", 33'(second_acc), 33'd6);
        chk("hold/sum", {bus4.Cout, bus4.S}, 33'd2);

        // K=1: one RUN cycle
        bus1.A = 8'd250; bus1.B = 8'd9; bus1.Cin = 1'b1; bus1.start = 1'b1;
        for (int c = 0; c <= 2; c++) begin
            @(negedge clk);
            if (c == 0) begin
                bus1.start = 1'b0; bus1.A = 8'd0; bus1.B = 8'd0; bus1.Cin = 1'b0;
            end
            chkb("k1/busy", bus1.busy, c == 0);
            chkb("k1/done", bus1.done, c == 1);
            if (c >= 1) chk("k1/sum", {24'h0, bus1.Cout, bus1.S}, {24'h0, 9'h104});
        end

        // reset in the middle of a run clears everything without a clock edge
        bus4.A = 32'hDEADBEEF; bus4.B = 32'h11111111; bus4.Cin = 1'b1; bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chkb("rst_mid/busy", bus4.busy, 1'b0);
        chkb("rst_mid/done", bus4.done, 1'b0);
        chk("rst_mid/sum", {bus4.Cout, bus4.S}, 33'h0);
        chk("rst_mid/sum_k1", {24'h0, bus1.Cout, bus1.S}, 33'h0);
        @(negedge clk);
        rst = 1'b0;
        op4(32'd5, 32'd7, 1'b1, 33'd13, "post_rst");

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom);
            op4(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + 33'(rc), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
